branch_fetch_unit: RTL and testbench
====================================

Name: branch_fetch_unit

Overview:
Instruction-fetch stage that consumes the branch controls produced by the opcode decoder (Branch, BranchType) once they reach the execute stage. It owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. Branch prediction is static not-taken: a taken branch redirects the PC and squashes the wrong-path fetch.

Parameters:
PC_WIDTH, 32, width of PC, branch target and instruction word
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000000, bubble word written into IF/ID on flush or reset
CNT_WIDTH, 16, width of the taken-branch counter

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
stall_i  input  1  load-use hold from hazard unit; freezes PC and IF/ID
branch_i  input  1  Branch control of the instruction in EX
branch_type_i  input  2  00 beq, 01 bne, 10 bge, 11 bgt
zero_i  input  1  ALU zero flag of rs-rt subtract in EX
sign_i  input  1  ALU result bit 31 of rs-rt subtract in EX
branch_target_i  input  PC_WIDTH  computed target (PC+4 + sext(imm)<<2)
imem_data_i  input  PC_WIDTH  instruction word read combinationally at imem_addr_o
imem_addr_o  output  PC_WIDTH  current PC
if_id_instr_o  output  PC_WIDTH  registered instruction to decode stage
if_id_pc4_o  output  PC_WIDTH  registered PC+4 accompanying if_id_instr_o
if_id_valid_o  output  1  1 = if_id_instr_o is a real fetched instruction
flush_o  output  1  combinational; 1 in the cycle a branch resolves taken
taken_cnt_o  output  CNT_WIDTH  saturating count of taken branches

Behaviour:
- Reset, when rst_i=1 at a posedge: pc<=RESET_PC, if_id_instr_o<=NOP_INSTR, if_id_pc4_o<=0, if_id_valid_o<=0, taken_cnt_o<=0. Reset wins over every other input. flush_o is forced to 0 while rst_i=1.
- imem_addr_o always equals pc, with bits [1:0] always 00.
- Branch condition, combinational:
  - beq: cond = zero_i
  - bne: cond = !zero_i
  - bge: cond = !sign_i
  - bgt: cond = !sign_i & !zero_i
- taken = branch_i & cond. flush_o = taken & !rst_i. Downstream stages use flush_o to bubble ID/EX in the same edge.
- Per posedge, with rst_i=0, evaluated in priority order:
  1. taken: pc<={branch_target_i[PC_WIDTH-1:2],2'b00}; if_id_instr_o<=NOP_INSTR; if_id_valid_o<=0; if_id_pc4_o<=0; taken_cnt_o increments and saturates at all-ones. Taken overrides stall_i.
  2. stall_i=1: pc and all IF/ID outputs hold their values.
  3. Otherwise: pc<=pc+4; if_id_instr_o<=imem_data_i; if_id_pc4_o<=pc+4; if_id_valid_o<=1.
- Latency: an instruction presented at PC in cycle N appears on if_id_* in cycle N+1. The taken-branch penalty is the squashed IF/ID slot plus the ID/EX bubble caused by flush_o.
- PC arithmetic is modulo 2^PC_WIDTH: pc=32'hFFFFFFFC advances to 32'h00000000, and if_id_pc4_o=0 in that case.
- branch_i=0 ignores branch_type_i, zero_i and sign_i entirely.
- X on branch_type_i while branch_i=0 must not propagate to flush_o.

Test Plan:
- Reset then 3 unstalled cycles, imem returning 32'h20080005, 32'h20090003, 32'h01095020 -> imem_addr_o 0,4,8,12; if_id_instr_o follows one cycle later; if_id_pc4_o 4,8,12; valid rises after the first edge.
- stall_i=1 for 2 cycles at pc=8 -> imem_addr_o stays 8 and if_id_* unchanged; on release pc goes to 12.
- branch_i=1, type 00, zero_i=1, target 32'h40 -> flush_o=1 that cycle; next cycle pc=32'h40, if_id_instr_o=NOP, valid=0, taken_cnt_o=1.
- Condition matrix, 4 types x (zero,sign) in {00,01,10}: beq taken only for zero=1; bne taken for zero=0; bge taken for sign=0; bgt taken only for zero=0,sign=0. Check flush_o and taken_cnt_o for every case.
- Simultaneous taken and stall_i=1 with target 32'h103 -> redirect wins; pc=32'h100 (low bits cleared).
- Wrap-around and reset: pc=32'hFFFFFFFC, no stall -> pc=0, if_id_pc4_o=0. Then rst_i=1 during a stall with branch_i=1 -> flush_o=0, pc=RESET_PC, valid=0, taken_cnt_o=0. With CNT_WIDTH=2 forced, 5 taken branches -> count saturates at 3.

Source files
------------

// File: rtl/branch_fetch_unit.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and resolves
// EX-stage branches with static not-taken prediction.
module branch_fetch_unit #(
  parameter int                    PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]   RESET_PC  = 32'h00000000,
  parameter logic [PC_WIDTH-1:0]   NOP_INSTR = 32'h00000000,
  parameter int                    CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 branch_i,
  input  logic [1:0]           branch_type_i,
  input  logic                 zero_i,
  input  logic                 sign_i,
  input  logic [PC_WIDTH-1:0]  branch_target_i,
  input  logic [PC_WIDTH-1:0]  imem_data_i,
  output logic [PC_WIDTH-1:0]  imem_addr_o,
  output logic [PC_WIDTH-1:0]  if_id_instr_o,
  output logic [PC_WIDTH-1:0]  if_id_pc4_o,
  output logic                 if_id_valid_o,
  output logic                 flush_o,
  output logic [CNT_WIDTH-1:0] taken_cnt_o
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[PC_WIDTH-1:2], 2'b00};

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                cond;
  logic                taken;
  logic                target_unused;

  assign pc_plus4      = pc + PC_WIDTH'(4);
  assign imem_addr_o   = pc;
  assign target_unused = ^branch_target_i[1:0];

  // Conditions are judged from the rs-rt subtract flags.
  always_comb begin
    cond = 1'b0;
    case (branch_type_i)
      2'b00:   cond = zero_i;
      2'b01:   cond = ~zero_i;
      2'b10:   cond = ~sign_i;
      2'b11:   cond = ~sign_i & ~zero_i;
      default: cond = 1'b0;
    endcase
  end

  // Gating with branch_i keeps unknown branch_type_i off flush_o.
  assign taken   = branch_i & cond;
  assign flush_o = taken & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc            <= RESET_PC_ALIGNED;
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= '0;
      if_id_valid_o <= 1'b0;
      taken_cnt_o   <= '0;
    end else if (taken) begin
      pc            <= {branch_target_i[PC_WIDTH-1:2], 2'b00};
      if_id_instr_o <= NOP_INSTR;
      if_id_pc4_o   <= '0;
      if_id_valid_o <= 1'b0;
      if (taken_cnt_o != {CNT_WIDTH{1'b1}})
        taken_cnt_o <= taken_cnt_o + CNT_WIDTH'(1);
    end else if (!stall_i) begin
      pc            <= pc_plus4;
      if_id_instr_o <= imem_data_i;
      if_id_pc4_o   <= pc_plus4;
      if_id_valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Self-checking bench for branch_fetch_unit: directed plan steps followed by
// random traffic, compared against a behavioural fetch model.
module tb_branch_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch, zero, sign;
  logic [1:0]  btype;
  logic [31:0] target, idata;

  logic [31:0] addr, instr, pc4;
  logic        valid, flush;
  logic [15:0] cnt;
  logic [31:0] s_addr, s_instr, s_pc4;
  logic        s_valid, s_flush;
  logic [1:0]  s_cnt;

  branch_fetch_unit #(.CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
    .branch_type_i(btype), .zero_i(zero), .sign_i(sign),
    .branch_target_i(target), .imem_data_i(idata),
    .imem_addr_o(addr), .if_id_instr_o(instr), .if_id_pc4_o(pc4),
    .if_id_valid_o(valid), .flush_o(flush), .taken_cnt_o(cnt)
  );

  branch_fetch_unit #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .branch_i(branch),
    .branch_type_i(btype), .zero_i(zero), .sign_i(sign),
    .branch_target_i(target), .imem_data_i(idata),
    .imem_addr_o(s_addr), .if_id_instr_o(s_instr), .if_id_pc4_o(s_pc4),
    .if_id_valid_o(s_valid), .flush_o(s_flush), .taken_cnt_o(s_cnt)
  );

  // Reference model state: architectural PC, IF/ID contents, taken count.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_of(input logic [1:0] ty, input logic z, input logic s);
    case (ty)
      2'd0:    return z;
      2'd1:    return !z;
      2'd2:    return !s;
      2'd3:    return !s && !z;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_regs();
    chk("imem_addr", addr, m_pc);
    chk("if_id_instr", instr, m_instr);
    chk("if_id_pc4", pc4, m_pc4);
    chk("if_id_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("taken_cnt", {16'd0, cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
    chk("taken_cnt_sat", {30'd0, s_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
    chk("sat_imem_addr", s_addr, m_pc);
  endtask

  // Called at posedge+1: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic r, input logic st, input logic br, input logic [1:0] ty,
                      input logic z, input logic s, input logic [31:0] tgt, input logic [31:0] d);
    logic tk;
    rst = r; stall = st; branch = br; btype = ty; zero = z; sign = s;
    target = tgt; idata = d;
    #1;
    tk = br && cond_of(ty, z, s);
    chk("flush", {31'd0, flush}, {31'd0, !r && tk});
    chk("flush_sat", {31'd0, s_flush}, {31'd0, !r && tk});
    chk("imem_addr_pre", addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
    end else if (tk) begin
      m_pc = tgt & 32'hFFFF_FFFC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_cnt++;
    end else if (!st) begin
      m_instr = d; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
    end
    #1;
    check_regs();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch = 1'b0; btype = 2'b00; zero = 1'b0; sign = 1'b0;
    target = 32'h0; idata = 32'h0;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    check_regs();

    // Sequential fetch
    step(0, 0, 0, 2'd0, 0, 0, 32'h0, 32'h20080005);
    step(0, 0, 0, 2'd0, 0, 0, 32'h0, 32'h20090003);
    // Stall at pc=8, then release
    step(0, 1, 0, 2'd0, 0, 0, 32'h0, 32'h01095020);
    step(0, 1, 0, 2'd0, 0, 0, 32'h0, 32'h01095020);
    step(0, 0, 0, 2'd0, 0, 0, 32'h0, 32'h01095020);
    chk("pc_after_stall", addr, 32'd12);

    // Taken beq
    step(0, 0, 1, 2'd0, 1, 0, 32'h40, 32'hDEADBEEF);
    chk("beq_redirect", addr, 32'h40);

    // Condition matrix
    for (int ty = 0; ty < 4; ty++)
      for (int zs = 0; zs < 3; zs++)
        step(0, 0, 1, ty[1:0], zs[1], zs[0], $urandom, $urandom);

    // Taken overrides stall, low target bits cleared
    step(0, 1, 1, 2'd1, 0, 0, 32'h103, 32'h12345678);
    chk("stall_redirect", addr, 32'h100);

    // Wrap-around
    step(0, 0, 1, 2'd2, 0, 0, 32'hFFFF_FFFC, 32'h0);
    step(0, 0, 0, 2'd0, 0, 0, 32'h0, 32'hCAFEF00D);
    chk("wrap_pc", addr, 32'h0);
    chk("wrap_pc4", pc4, 32'h0);

    // Reset wins over stall and a taken branch
    step(1, 1, 1, 2'd0, 1, 0, 32'h80, 32'h11111111);

    // Saturation of the 2-bit counter
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 2'd1, 0, 0, 32'h200 + 32'(i * 16), 32'h0);
    chk("sat_cnt", {30'd0, s_cnt}, 32'd3);

    // Unknown branch type with branch_i low
    step(0, 0, 0, 2'bxx, 1'bx, 1'bx, 32'h0, 32'h55555555);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
